mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-master arbiter sharing the single-port synchronous memory `Mem` over the bus signals `we`, `addr`, `dataM2S` and `dataS2M`.
- Master 0 is the instruction fetch port; master 1 is the load/store port.
- Per cycle the block:
  - grants at most one request;
  - drives the memory from the winner;
  - returns read data to the winner one cycle later.
- Fully pipelined: one access per cycle, no stall cycles.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  master 0 request; held until granted.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle (combinational).
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- mem_we  out  1  to memory `we`.
- mem_addr  out  ADDR_W  to memory `addr`.
- mem_wdata  out  DATA_W  to memory `dataM2S`.
- mem_rdata  in  DATA_W  from memory `dataS2M`; valid the cycle after the address is presented.

Behaviour:
- Reset values, asynchronous on rst=1:
  - prio_ptr=0 (master 0 favoured);
  - rd_pend=0, rd_owner=0;
  - m0_rvalid=m1_rvalid=0.
  - While rst=1: gnt outputs 0, mem_we=0.
- Arbitration (combinational, each cycle):
  - One requester: that requester wins.
  - Both requesting: the master selected by prio_ptr wins.
  - Neither: no grant; mem_we=0, mem_addr=0, mem_wdata=0.
- Grant: mX_gnt=1 only for the winner. The memory ports mirror the winner's we/addr/wdata. The access is committed on the rising edge at the end of that cycle.
- Round-robin pointer: on any grant, prio_ptr <= index of the loser, i.e. the non-winning master. Result:
  - With continuous contention, grants alternate 0,1,0,1.
  - Maximum wait is 1 cycle.
- Writes: complete at the grant edge. No response is returned to the master.
- Read tracking (granted read, i.e. we=0): rd_pend <= 1 and rd_owner <= winner at that edge. Otherwise rd_pend <= 0.
- Read response, the cycle after a granted read:
  - m{rd_owner}_rvalid=1 and m{rd_owner}_rdata=mem_rdata.
  - The other master has rvalid=0.
  - Latency from grant to rvalid is exactly 1 cycle.
- rdata outputs: mX_rdata = mem_rdata when that master's rvalid=1, else 0.
- Back-to-back reads (same or alternating masters): one rvalid per cycle, in grant order.
- Read-after-write to the same address in consecutive grants returns the new data; the memory writes at the grant edge.
- Request semantics:
  - A master holds req/we/addr/wdata stable until it sees gnt.
  - Dropping req before gnt cancels the request with no side effects.
- Reset mid-operation: a pending read is discarded (no rvalid after reset release), and prio_ptr returns to 0.
- First cycle after reset release: arbitration is normal; no rvalid is produced.

Optional Feature:
- ARB_FIXED_PRIO_EN defined:
  - Master 0 always wins on contention.
  - prio_ptr is removed and master 1 may starve.
  - All other behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then m0 write addr 8'hff data 32'hffffffff; next cycle m0 read 8'hff. Required: m0_gnt=1 in both cycles; m0_rvalid=1 with m0_rdata=32'hffffffff one cycle after the read grant; m1_rvalid=0 throughout.
- m0 and m1 both hold read requests, to 8'h10 (preloaded 32'h11111111) and 8'h20 (32'h22222222), starting right after reset. Required: cycle n m0_gnt; cycle n+1 m1_gnt; m0_rvalid at n+1 with 32'h11111111; m1_rvalid at n+2 with 32'h22222222.
- Continuous contention for 6 cycles. Required: grant sequence 0,1,0,1,0,1 in round-robin mode; 0,0,0,0,0,0 with ARB_FIXED_PRIO_EN.
- m1 writes 8'h05=32'hdeadbeef in cycle n; m0 reads 8'h05 in cycle n+1. Required: m0_rdata=32'hdeadbeef at n+2.
- m0 read granted, then rst pulsed high for 1 cycle before the response cycle. Required: m0_rvalid stays 0; after reset release, prio_ptr=0, so m0 wins the first contention.
- No requests for 4 cycles. Required: mem_we=0, mem_addr=0, all gnt and rvalid outputs 0.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// single-port synchronous memory.
//   m0_* : instruction fetch port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   m1_* : load/store port, same shape as m0_*
//   mem_*: memory side (we/addr/wdata towards memory, rdata back from memory)
// Modports:
//   slave  : arbiter view (consumes requests and mem_rdata, drives the rest)
//   master : requester/memory view, the mirror image of slave
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter in front of a single-port synchronous memory.
// One access per cycle: the winner is granted combinationally, drives the
// memory, and (for reads) gets the memory data back exactly one cycle later.
// Contention is resolved round-robin: after every grant the loser is
// favoured next time.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : mem_bus_arbiter_if.slave (m0_*, m1_* master ports, mem_* memory port)
// Build option:
//   ARB_FIXED_PRIO_EN : master 0 always wins contention; no priority pointer
//                       is kept and master 1 may starve.
module mem_bus_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_arbiter_if.slave bus
);

  logic              any_req;
  logic              gnt_valid;
  logic              win;        // 0 = master 0, 1 = master 1
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              rd_grant;

  logic              rd_pend;
  logic              rd_owner;

`ifndef ARB_FIXED_PRIO_EN
  logic              prio_ptr;
`endif

  // Winner selection
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
`ifdef ARB_FIXED_PRIO_EN
    win     = bus.m1_req & ~bus.m0_req;
`else
    if (bus.m0_req && bus.m1_req) begin
      win = prio_ptr;
    end else begin
      win = bus.m1_req;
    end
`endif
    // No grant is issued while reset is held, even with requests present.
    gnt_valid = any_req & ~rst;
  end

  // Memory drive from the winner; all-zero when nothing is granted
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_valid) begin
      if (win) begin
        sel_we    = bus.m1_we;
        sel_addr  = bus.m1_addr;
        sel_wdata = bus.m1_wdata;
      end else begin
        sel_we    = bus.m0_we;
        sel_addr  = bus.m0_addr;
        sel_wdata = bus.m0_wdata;
      end
    end
    rd_grant = gnt_valid & ~sel_we;
  end

  assign bus.m0_gnt    = gnt_valid & ~win;
  assign bus.m1_gnt    = gnt_valid &  win;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
  // Favour the loser of the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_ptr <= 1'b0;
    end else if (gnt_valid) begin
      prio_ptr <= ~win;
    end
  end
`endif

  // Read tracking: memory data arrives one cycle after the address, so the
  // owner of the granted read is remembered for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= rd_grant;
      if (rd_grant) begin
        rd_owner <= win;
      end
    end
  end

  assign bus.m0_rvalid = rd_pend & ~rd_owner;
  assign bus.m1_rvalid = rd_pend &  rd_owner;
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized two-master traffic with occasional resets,
// compared every cycle against a queue-based reference model.
module tb_mem_bus_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned a);
    logic [31:0] v;
    if (a == 32'h10) return 32'h11111111;
    if (a == 32'h20) return 32'h22222222;
    v = 32'h9e3779b9 * (a + 32'd1);
    return v;
  endfunction

  // Synchronous single-port memory
  logic [31:0] mem [256];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Reference model: shadow memory plus a queue of promised read responses
  typedef struct packed {
    logic [31:0] due;
    logic        owner;
    logic [31:0] data;
  } resp_t;

  initial begin
    logic [31:0] shadow [256];
    resp_t       q[$];
    resp_t       r;
    int unsigned cyc_n;
    logic        m_prio;
    logic        r0, r1, w, any, we_s;
    logic [7:0]  addr_s;
    logic [31:0] wd_s;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    cyc_n  = 0;
    m_prio = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst) begin
        q.delete();
        m_prio = 1'b0;
        check("rst_m0_gnt", bus.m0_gnt, 0);
        check("rst_m1_gnt", bus.m1_gnt, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_m0_rvalid", bus.m0_rvalid, 0);
        check("rst_m1_rvalid", bus.m1_rvalid, 0);
      end else begin
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (q.size() > 0 && q[0].due == cyc_n) begin
          r = q.pop_front();
          if (r.owner) begin ev1 = 1'b1; ed1 = r.data; end
          else         begin ev0 = 1'b1; ed0 = r.data; end
        end
        r0  = bus.m0_req;
        r1  = bus.m1_req;
        any = r0 | r1;
`ifdef ARB_FIXED_PRIO_EN
        w = (r0 && r1) ? 1'b0 : r1;
`else
        w = (r0 && r1) ? m_prio : r1;
`endif
        we_s   = any ? (w ? bus.m1_we    : bus.m0_we)    : 1'b0;
        addr_s = any ? (w ? bus.m1_addr  : bus.m0_addr)  : 8'h00;
        wd_s   = any ? (w ? bus.m1_wdata : bus.m0_wdata) : 32'h0;
        check("m0_gnt",    bus.m0_gnt,    any && !w);
        check("m1_gnt",    bus.m1_gnt,    any && w);
        check("mem_we",    bus.mem_we,    we_s);
        check("mem_addr",  bus.mem_addr,  addr_s);
        check("mem_wdata", bus.mem_wdata, wd_s);
        check("m0_rvalid", bus.m0_rvalid, ev0);
        check("m0_rdata",  bus.m0_rdata,  ed0);
        check("m1_rvalid", bus.m1_rvalid, ev1);
        check("m1_rdata",  bus.m1_rdata,  ed1);
        if (any) begin
          if (we_s) shadow[addr_s] = wd_s;
          else      q.push_back('{due: cyc_n + 1, owner: w, data: shadow[addr_s]});
          m_prio = ~w;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [7:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic        rq [2];
    logic        wq [2];
    logic [7:0]  aq [2];
    logic [31:0] dq [2];
    logic        g  [2];
    logic        exp_w;

    idle_all();
    do_reset(2);

    // Write then read back 8'hff from master 0
    drive(0, 1'b1, 1'b1, 8'hff, 32'hffffffff);
    @(negedge clk);
    check("t1_wr_gnt", bus.m0_gnt, 1);
    check("t1_m1_rvalid_a", bus.m1_rvalid, 0);
    tick();
    drive(0, 1'b1, 1'b0, 8'hff, 32'h0);
    @(negedge clk);
    check("t1_rd_gnt", bus.m0_gnt, 1);
    check("t1_m1_rvalid_b", bus.m1_rvalid, 0);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("t1_rvalid", bus.m0_rvalid, 1);
    check("t1_rdata", bus.m0_rdata, 32'hffffffff);
    check("t1_m1_rvalid_c", bus.m1_rvalid, 0);
    tick();

    // Both masters read straight out of reset
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 8'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h20, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t2_n_m0_gnt", bus.m0_gnt, 1);
    check("t2_n_m1_gnt", bus.m1_gnt, 0);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("t2_n1_m1_gnt", bus.m1_gnt, 1);
    check("t2_n1_m0_rvalid", bus.m0_rvalid, 1);
    check("t2_n1_m0_rdata", bus.m0_rdata, 32'h11111111);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("t2_n2_m1_rvalid", bus.m1_rvalid, 1);
    check("t2_n2_m1_rdata", bus.m1_rdata, 32'h22222222);
    check("t2_n2_m0_rvalid", bus.m0_rvalid, 0);
    tick();

    // Six cycles of continuous contention
    do_reset(1);
    drive(0, 1'b1, 1'b0, 8'h01, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h02, 32'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_w = 1'b0;
`else
      exp_w = (i % 2) == 1;
`endif
      @(negedge clk);
      check("t3_m0_gnt", bus.m0_gnt, !exp_w);
      check("t3_m1_gnt", bus.m1_gnt, exp_w);
      tick();
    end
    idle_all();
    tick();

    // m1 write followed by m0 read of the same address
    drive(1, 1'b1, 1'b1, 8'h05, 32'hdeadbeef);
    @(negedge clk);
    check("t4_m1_gnt", bus.m1_gnt, 1);
    tick();
    drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(0, 1'b1, 1'b0, 8'h05, 32'h0);
    @(negedge clk);
    check("t4_m0_gnt", bus.m0_gnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    check("t4_rvalid", bus.m0_rvalid, 1);
    check("t4_rdata", bus.m0_rdata, 32'hdeadbeef);
    tick();

    // Reset between a read grant and its response
    drive(0, 1'b1, 1'b0, 8'h30, 32'h0);
    @(negedge clk);
    check("t5_rd_gnt", bus.m0_gnt, 1);
    tick();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1, 1'b1, 1'b1, 8'h07, 32'h55);
    @(negedge clk);
    check("t5_rst_rvalid", bus.m0_rvalid, 0);
    check("t5_rst_m1_gnt", bus.m1_gnt, 0);
    check("t5_rst_mem_we", bus.mem_we, 0);
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h40, 32'h0);
    drive(1, 1'b1, 1'b0, 8'h41, 32'h0);
    @(negedge clk);
    check("t5_post_rvalid", bus.m0_rvalid, 0);
    check("t5_post_m0_gnt", bus.m0_gnt, 1);
    check("t5_post_m1_gnt", bus.m1_gnt, 0);
    tick();
    idle_all();
    tick();
    tick();

    // Idle bus
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_mem_we", bus.mem_we, 0);
      check("t6_mem_addr", bus.mem_addr, 0);
      check("t6_m0_gnt", bus.m0_gnt, 0);
      check("t6_m1_gnt", bus.m1_gnt, 0);
      check("t6_m0_rvalid", bus.m0_rvalid, 0);
      check("t6_m1_rvalid", bus.m1_rvalid, 0);
      tick();
    end

    // Randomized traffic; requests are held until granted or cancelled
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; wq[m] = 1'b0; aq[m] = 8'h00; dq[m] = 32'h0;
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      g[0] = bus.m0_gnt;
      g[1] = bus.m1_gnt;
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        for (int m = 0; m < 2; m++) rq[m] = 1'b0;
        idle_all();
        continue;
      end
      for (int m = 0; m < 2; m++) begin
        if (rq[m] && !g[m]) begin
          if ($urandom_range(0, 9) == 0) rq[m] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          rq[m] = 1'b1;
          wq[m] = $urandom_range(0, 1) == 1;
          aq[m] = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom_range(0, 15));
          dq[m] = $urandom;
        end else begin
          rq[m] = 1'b0;
        end
        drive(m, rq[m], wq[m], aq[m], dq[m]);
      end
    end

    rst = 1'b0;
    idle_all();
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
